// File: rtl/tone_synth.sv
// tone_synth: square-wave tone generator driven by a sequencer's (enable, frequency) pair.
// An accumulator modulo CLK_HZ advances by 2*freq each cycle. Each time it wraps, the
// wave toggles, so the average frequency is exactly freq Hz with no divider or multiplier.
// Frequency changes and stops are applied only at waveform edges, so notes never click.
module tone_synth #(
    parameter int CLK_HZ    = 50000000,
    parameter int AMPLITUDE = 8192
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic [15:0]        iFreq,
    output logic               oWave,
    output logic signed [15:0] oSample,
    output logic               oActive,
    output logic               oPeriod
);

    // One extra bit so acc + 2*freq (< 2*CLK_HZ) never overflows.
    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam int HALF  = CLK_HZ / 2;
    // If CLK_HZ/2 exceeds the 16-bit range, no request can exceed it.
    localparam logic [15:0]        HALF16  = (HALF > 65535) ? 16'hFFFF : HALF[15:0];
    localparam logic [ACC_W-1:0]   CLK_W   = ACC_W'(CLK_HZ);
    localparam logic signed [15:0] AMP_POS = 16'(AMPLITUDE);
    localparam logic signed [15:0] AMP_NEG = -AMP_POS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  wave_q, wave_d;
    logic [15:0]           freq_q, freq_d;
    logic                  period_q, period_d;
    logic signed [15:0]    sample_q, sample_d;
    logic                  active_q, active_d;

    logic [15:0]           freq_clamp;
    logic [ACC_W-1:0]      step;
    logic [ACC_W-1:0]      sum;
    logic                  toggle;
    logic                  stopping;

    // Input clamp and accumulator arithmetic shared by all states.
    always_comb begin
        freq_clamp = (iFreq > HALF16) ? HALF16 : iFreq;
        step       = ACC_W'({freq_q, 1'b0});
        sum        = acc_q + step;
        toggle     = (sum >= CLK_W);
        // A re-raised enable in STOPPING cancels the stop, so only the live level matters.
        stopping   = ~iEnable;
    end

    // State register plus the datapath registers, with synchronous reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            wave_q   <= 1'b0;
            freq_q   <= '0;
            period_q <= 1'b0;
            sample_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            wave_q   <= wave_d;
            freq_q   <= freq_d;
            period_q <= period_d;
            sample_q <= sample_d;
            active_q <= active_d;
        end
    end

    // Next-state logic: phase accumulation, edge-aligned frequency updates and stops.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wave_d   = wave_q;
        freq_d   = freq_q;
        period_d = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d  = '0;
                wave_d = 1'b0;
                if (iEnable) begin
                    state_d = RUN;
                    freq_d  = freq_clamp;
                    wave_d  = (freq_clamp != 16'd0);
                end
            end
            default: begin
                if (freq_q == 16'd0) begin
                    acc_d = '0;
                    if (stopping) begin
                        state_d = IDLE;
                        wave_d  = 1'b0;
                    end else begin
                        // Silence: keep polling the request so a new note starts fresh.
                        state_d = RUN;
                        freq_d  = freq_clamp;
                        wave_d  = (freq_clamp != 16'd0);
                    end
                end else if (stopping) begin
                    if (toggle) begin
                        // Finish on a waveform edge. A pending fall is taken, but a pending rise is dropped.
                        state_d  = IDLE;
                        wave_d   = 1'b0;
                        acc_d    = '0;
                        period_d = wave_q;
                    end else begin
                        state_d = STOPPING;
                        acc_d   = sum;
                    end
                end else begin
                    state_d = RUN;
                    if (toggle) begin
                        acc_d = sum - CLK_W;
                        if (wave_q) begin
                            wave_d   = 1'b0;
                            period_d = 1'b1;
                            freq_d   = freq_clamp;
                        end else begin
                            wave_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
        endcase
    end

    // Output decode from next-state values, so every output is registered and aligned.
    always_comb begin
        active_d = (state_d != IDLE);
        if (wave_d)
            sample_d = AMP_POS;
        else if (active_d && (freq_d != 16'd0))
            sample_d = AMP_NEG;
        else
            sample_d = '0;
    end

    assign oWave   = wave_q;
    assign oPeriod = period_q;
    assign oSample = sample_q;
    assign oActive = active_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth at CLK_HZ=1000 so waveform timing is easy to hand-compute.
module tb_tone_synth;

    logic               iClock;
    logic               iReset;
    logic               iEnable;
    logic [15:0]        iFreq;
    logic               oWave;
    logic signed [15:0] oSample;
    logic               oActive;
    logic               oPeriod;

    int total = 0;
    int bad   = 0;

    tone_synth #(
        .CLK_HZ    (1000),
        .AMPLITUDE (8192)
    ) dut (
        .iClock  (iClock),
        .iReset  (iReset),
        .iEnable (iEnable),
        .iFreq   (iFreq),
        .oWave   (oWave),
        .oSample (oSample),
        .oActive (oActive),
        .oPeriod (oPeriod)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int w, input int p, input int a, input int s);
        chk({tag, ".wave"},   int'(oWave),    w);
        chk({tag, ".period"}, int'(oPeriod),  p);
        chk({tag, ".active"}, int'(oActive),  a);
        chk({tag, ".sample"}, int'(oSample),  s);
    endtask

    // Advance n cycles, checking against bit patterns whose MSB is the first cycle.
    // This is only used where the live frequency is nonzero, so the sample follows wave/active.
    task automatic run_seq(input string name, input int n,
                           input logic [31:0] wv, input logic [31:0] pv, input logic [31:0] av);
        int w, p, a, s;
        for (int i = 0; i < n; i++) begin
            tick();
            w = int'(wv[n-1-i]);
            p = int'(pv[n-1-i]);
            a = int'(av[n-1-i]);
            s = (w == 1) ? 8192 : ((a == 1) ? -8192 : 0);
            chk_all($sformatf("%s[%0d]", name, i), w, p, a, s);
        end
        $display("txn %s: %0d cycles checked", name, n);
    endtask

    initial begin
        iReset  = 1'b1;
        iEnable = 1'b0;
        iFreq   = 16'd0;
        tick();
        chk_all("reset0", 0, 0, 0, 0);
        $display("txn initial reset");
        iReset = 1'b0;

        // Steady 100 Hz tone gives 5 cycles high, then 5 cycles low.
        iEnable = 1'b1;
        iFreq   = 16'd100;
        run_seq("f100", 20, 32'b11111000001111100000, 32'b00000100000000010000, 32'hFFFFF);
        run_seq("f100b", 2, 32'b11, 32'b00, 32'b11);

        // Change to 250 Hz two cycles into a high half. The 100 Hz period completes first.
        iFreq = 16'd250;
        run_seq("f250", 13, 32'b1110011001100, 32'b0001000100010, 32'h1FFF);

        // Reset mid-tone with enable still high. Reset must win over the tone.
        iReset = 1'b1;
        tick();
        chk_all("reset_mid", 0, 0, 0, 0);
        $display("txn reset mid-tone");
        iReset  = 1'b0;
        iEnable = 1'b0;
        run_seq("idle", 2, 32'b00, 32'b00, 32'b00);

        // Stop during a high half. The wave finishes the half, then pulses once.
        iFreq   = 16'd100;
        iEnable = 1'b1;
        run_seq("stopH_a", 2, 32'b11, 32'b00, 32'b11);
        iEnable = 1'b0;
        run_seq("stopH_b", 5, 32'b11100, 32'b00010, 32'b11100);

        // Stop during a low half. The rise is suppressed and there is no pulse.
        iEnable = 1'b1;
        run_seq("stopL_a", 7, 32'b1111100, 32'b0000010, 32'b1111111);
        iEnable = 1'b0;
        run_seq("stopL_b", 5, 32'b00000, 32'b00000, 32'b11100);

        // Stop for a single edge, then re-raise. The phase continues without a reset.
        iEnable = 1'b1;
        run_seq("rer_a", 2, 32'b11, 32'b00, 32'b11);
        iEnable = 1'b0;
        run_seq("rer_b", 1, 32'b1, 32'b0, 32'b1);
        iEnable = 1'b1;
        run_seq("rer_c", 8, 32'b11000001, 32'b00100000, 32'hFF);
        iReset = 1'b1;
        tick();
        iReset  = 1'b0;
        iEnable = 1'b0;

        // Enable with a zero frequency holds silence while active. A later note starts fresh.
        iEnable = 1'b1;
        iFreq   = 16'd0;
        tick();
        chk_all("sil0", 0, 0, 1, 0);
        tick();
        chk_all("sil1", 0, 0, 1, 0);
        $display("txn silence active");
        iFreq = 16'd100;
        run_seq("sil_start", 6, 32'b111110, 32'b000001, 32'b111111);
        iReset = 1'b1;
        tick();
        iReset  = 1'b0;
        iEnable = 1'b0;

        // 700 Hz clamps to 500 Hz, so the wave toggles every cycle.
        iEnable = 1'b1;
        iFreq   = 16'd700;
        run_seq("clamp_a", 4, 32'b1010, 32'b0101, 32'b1111);
        // Enable drops and returns between edges, so no edge sees the drop and nothing changes.
        #2 iEnable = 1'b0;
        #2 iEnable = 1'b1;
        run_seq("clamp_b", 4, 32'b1010, 32'b0101, 32'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
